// File: rtl/ssp_pkg.sv
// Shared SSP definitions used by both the receive and transmit paths.
package ssp_pkg;

    localparam int SSP_DATA_WIDTH = 8;
    localparam int SSP_CNT_W      = $clog2(SSP_DATA_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ssp_state_e;

endpackage

// File: rtl/ssp_rx_logic_if.sv
// Serial-in / FIFO-out bundle of the SSP receive front end.
interface ssp_rx_logic_if #(parameter int DATA_WIDTH = ssp_pkg::SSP_DATA_WIDTH);

    logic                  SSPCLKIN;
    logic                  SSPFSSIN;
    logic                  SSPRXD;
    logic                  SSPRXINTR;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  rx_ready;
    logic                  RXOVR;
    logic                  rx_busy;

    // slave is the receiver; master drives the serial line and FIFO-full flag
    modport slave (
        input  SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
        output RxData, rx_ready, RXOVR, rx_busy
    );

    modport master (
        output SSPCLKIN, SSPFSSIN, SSPRXD, SSPRXINTR,
        input  RxData, rx_ready, RXOVR, rx_busy
    );

endinterface

// File: rtl/ssp_edge_detect.sv
// Falling-edge detector for the oversampled serial bit clock.
module ssp_edge_detect (
    input  logic PCLK,
    input  logic CLEAR,
    input  logic SSPCLKIN,
    output logic s_en
);

    logic clk_q;

    always_ff @(posedge PCLK) begin
        if (CLEAR) clk_q <= 1'b0;
        else       clk_q <= SSPCLKIN;
    end

    assign s_en = clk_q & ~SSPCLKIN;

endmodule

// File: rtl/ssp_rx_logic.sv
// SSP receive deserialiser: frames MSB-first words and hands them to the RX FIFO
// through a one-deep holding buffer with sticky overrun.
module ssp_rx_logic
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
    input  logic           PCLK,
    input  logic           CLEAR,
    ssp_rx_logic_if.slave  bus
);

    localparam logic [SSP_CNT_W-1:0] LAST = SSP_CNT_W'(DATA_WIDTH - 1);

    logic                  s_en;
    ssp_state_e            state, state_n;
    logic [SSP_CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_WIDTH-2:0] sr, sr_n;
    logic [DATA_WIDTH-1:0] word;
    logic                  done;
    logic                  pending;

    ssp_edge_detect u_edge (
        .PCLK     (PCLK),
        .CLEAR    (CLEAR),
        .SSPCLKIN (bus.SSPCLKIN),
        .s_en     (s_en)
    );

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        done    = 1'b0;
        word    = {sr, bus.SSPRXD};
        case (state)
            IDLE: begin
                if (s_en && bus.SSPFSSIN) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    if (cnt == LAST) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        sr_n    = word[DATA_WIDTH-2:0];
                        state_n = bus.SSPFSSIN ? SHIFT : IDLE;
                    end else if (bus.SSPFSSIN) begin
                        // sync inside a word: drop the partial word silently
                        cnt_n = '0;
                    end else begin
                        sr_n  = word[DATA_WIDTH-2:0];
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output stage. A fresh word that lands right after a strobe is parked so
    // the FIFO never sees two strobes in a row.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            bus.RxData   <= '0;
            bus.rx_ready <= 1'b0;
            bus.RXOVR    <= 1'b0;
            pending      <= 1'b0;
        end else begin
            bus.rx_ready <= 1'b0;
            if (pending) begin
                if (!bus.SSPRXINTR) begin
                    bus.rx_ready <= 1'b1;
                    pending      <= 1'b0;
                end
                if (done) bus.RXOVR <= 1'b1;
            end else if (done) begin
                bus.RxData <= word;
                if (!bus.SSPRXINTR && !bus.rx_ready) bus.rx_ready <= 1'b1;
                else                                 pending      <= 1'b1;
            end
        end
    end

    assign bus.rx_busy = (state == SHIFT);

endmodule

// File: tb/tb_ssp_rx_logic.sv
// Scoreboard bench for ssp_rx_logic: expected words queued at stimulus time,
// checked by a monitor on every strobe.
module tb_ssp_rx_logic;

    logic PCLK = 1'b0;
    logic CLEAR;

    ssp_rx_logic_if #(.DATA_WIDTH(8)) bus ();

    ssp_rx_logic #(.DATA_WIDTH(8)) dut (
        .PCLK  (PCLK),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobes = 0;
    int last_strobe_cyc = 0;
    int prev_strobe_cyc = 0;
    logic prev_rdy = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge PCLK) cyc++;

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge PCLK) begin
        if (bus.rx_ready === 1'b1) begin
            logic [7:0] e;
            checks++;
            if (prev_rdy) begin
                errors++;
                $display("FAIL strobe_consecutive at cycle %0d", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe RxData=%h expected no strobe", bus.RxData);
            end else begin
                e = exp_q.pop_front();
                if (bus.RxData !== e) begin
                    errors++;
                    $display("FAIL strobe_data RxData=%h expected %h", bus.RxData, e);
                end
            end
            strobes++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
        end
        prev_rdy = (bus.rx_ready === 1'b1);
    end

    task automatic send_bit(input logic fss, input logic d);
        @(negedge PCLK);
        bus.SSPCLKIN = 1'b1;
        bus.SSPFSSIN = fss;
        bus.SSPRXD   = d;
        @(negedge PCLK);
        bus.SSPCLKIN = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic sync, input logic lsb_fss);
        if (sync) send_bit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit((i == 0) ? lsb_fss : 1'b0, w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
        bus.SSPFSSIN = 1'b0;
    endtask

    task automatic test_reset;
        CLEAR = 1'b1;
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        checks++;
        if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
        checks++;
        if (bus.RxData !== 8'h00) begin errors++; $display("FAIL reset_RxData got %h want 00", bus.RxData); end
        checks++;
        if (bus.RXOVR !== 1'b0) begin errors++; $display("FAIL reset_RXOVR got %b want 0", bus.RXOVR); end
        checks++;
        if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", bus.rx_busy); end
    endtask

    task automatic test_single;
        int s0 = strobes;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        @(negedge PCLK);
        checks++;
        if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL single_latency rx_ready=%b want 1", bus.rx_ready); end
        @(negedge PCLK);
        checks++;
        if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL single_width rx_ready=%b want 0", bus.rx_ready); end
        idle(6);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL single_count got %0d want 1", strobes - s0); end
        checks++;
        if (bus.RXOVR !== 1'b0) begin errors++; $display("FAIL single_RXOVR got %b want 0", bus.RXOVR); end
    endtask

    task automatic test_back_to_back;
        int s0 = strobes;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (strobes - s0 != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", strobes - s0); end
        checks++;
        if (last_strobe_cyc - prev_strobe_cyc != 16) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles want 16", last_strobe_cyc - prev_strobe_cyc);
        end
    endtask

    task automatic test_backpressure;
        int s0 = strobes;
        bus.SSPRXINTR = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(10);
        checks++;
        if (strobes != s0) begin errors++; $display("FAIL full_no_strobe got %0d strobes want 0", strobes - s0); end
        bus.SSPRXINTR = 1'b0;
        @(negedge PCLK);
        checks++;
        if (bus.rx_ready !== 1'b1 || bus.RxData !== 8'h5A) begin
            errors++;
            $display("FAIL full_release rx_ready=%b RxData=%h want 1/5a", bus.rx_ready, bus.RxData);
        end
        idle(4);
    endtask

    task automatic test_midframe_sync;
        int s0 = strobes;
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(6);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL midframe_count got %0d want 1", strobes - s0); end
        checks++;
        if (bus.RXOVR !== 1'b0) begin errors++; $display("FAIL midframe_RXOVR got %b want 0", bus.RXOVR); end
    endtask

    task automatic test_overrun;
        int s0 = strobes;
        bus.SSPRXINTR = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (bus.RXOVR !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", bus.RXOVR); end
        send_frame(8'h22, 1'b1, 1'b0);
        @(negedge PCLK);
        checks++;
        if (bus.RXOVR !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", bus.RXOVR); end
        bus.SSPRXINTR = 1'b0;
        idle(6);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL overrun_count got %0d want 1", strobes - s0); end
        checks++;
        if (bus.RXOVR !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", bus.RXOVR); end
    endtask

    task automatic test_reset_midframe;
        int s0 = strobes;
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        @(negedge PCLK);
        CLEAR = 1'b1;
        @(negedge PCLK);
        CLEAR = 1'b0;
        checks++;
        if (bus.rx_ready !== 1'b0 || bus.RxData !== 8'h00 || bus.RXOVR !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_midframe rdy=%b data=%h ovr=%b busy=%b want all 0",
                     bus.rx_ready, bus.RxData, bus.RXOVR, bus.rx_busy);
        end
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(6);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL clear_next_count got %0d want 1", strobes - s0); end
    endtask

    initial begin
        CLEAR         = 1'b1;
        bus.SSPCLKIN  = 1'b0;
        bus.SSPFSSIN  = 1'b0;
        bus.SSPRXD    = 1'b0;
        bus.SSPRXINTR = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_midframe_sync;
        test_overrun;
        test_reset_midframe;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes %0d words never delivered, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssp_rx_logic.md
# ssp_rx_logic

Receive front end of the SSP port: deserialises the TI synchronous-serial frame arriving on SSPRXD/SSPCLKIN/SSPFSSIN into 8-bit words. It presents each word to the receive FIFO on RxData with a one-cycle rx_ready strobe. It sits directly upstream of the receive FIFO and uses the FIFO's full indication (SSPRXINTR) for back-pressure. A word that completes while the FIFO is full is parked in a one-deep holding buffer, and overruns are flagged.

## Interface
- DATA_WIDTH, 8, frame/word width in bits (MSB first)
- PCLK  in  1  system clock; all logic on rising edge. Single clock: SSPCLKIN is sampled as data. Its frequency is at most PCLK/2.
- CLEAR  in  1  synchronous, active-high reset
- SSPCLKIN  in  1  serial bit clock from external master; bits sampled on its falling edge
- SSPFSSIN  in  1  frame sync; high at the sample point one bit before the MSB
- SSPRXD  in  1  serial receive data
- SSPRXINTR  in  1  FIFO full from receive FIFO; high = do not strobe
- RxData  out  DATA_WIDTH  held word presented to FIFO; reset 0
- rx_ready  out  1  one-cycle write strobe; RxData valid while high; reset 0
- RXOVR  out  1  sticky overrun flag; reset 0, cleared only by CLEAR
- rx_busy  out  1  high while FSM in SHIFT; reset 0

## Operation
- Edge detect: clk_q <= SSPCLKIN each cycle, reset value 0. The sample enable is s_en = clk_q & ~SSPCLKIN. All serial sampling (SSPRXD, SSPFSSIN) happens only on PCLK edges where s_en = 1.
- FSM states IDLE, SHIFT; 3-bit bit counter cnt; shift register sr.
- IDLE: on s_en & SSPFSSIN -> SHIFT, cnt = 0. SSPRXD at this edge is ignored.
- SHIFT, s_en, cnt < 7, SSPFSSIN = 0: sr <= {sr[6:0], SSPRXD}, cnt++.
- SHIFT, s_en, cnt < 7, SSPFSSIN = 1: abort the partial word with no output and no flag. Restart with cnt = 0; the next s_en captures the MSB.
- SHIFT, s_en, cnt = 7: the word is complete, with {sr[6:0], SSPRXD} as the LSB. If SSPFSSIN = 1, stay in SHIFT with cnt = 0 (back-to-back frame); otherwise go to IDLE.
- Word completion when pending = 0:
  - RxData <= word.
  - If SSPRXINTR = 0: rx_ready <= 1.
  - If SSPRXINTR = 1: pending <= 1, rx_ready stays 0.
- pending = 1, SSPRXINTR = 0 at an edge: rx_ready <= 1, pending <= 0. RxData is unchanged.
- Word completion while pending = 1, including the edge where pending releases: the new word is dropped, RXOVR <= 1, and RxData is not modified.
- rx_ready is never high on two consecutive cycles.

## Timing
- Latency: rx_ready is high in the cycle immediately after the PCLK edge that sampled the LSB, provided the FIFO is not full.
- rx_ready and RxData are registered. The FIFO samples them on the next PCLK edge.
- After SSPRXINTR falls, a parked word strobes in the cycle following the first edge at which SSPRXINTR = 0 is seen.
- Minimum frame: 9 SSPCLKIN periods (sync + 8 bits). Back-to-back frames take 8 periods each.
- CLEAR high at any edge, including mid-frame or with pending = 1: all outputs and registers return to reset values on that edge. This covers IDLE, cnt, sr, pending and clk_q. The partial or parked word is lost without setting RXOVR.
- CLEAR has priority over all other events on the same edge.

## Structure
- Shared package ssp_pkg holds the following; the transmit side uses the same definitions:
  - the FSM state typedef (IDLE, SHIFT);
  - the DATA_WIDTH default;
  - the bit-counter width constant.
- One sub-module, ssp_edge_detect: registers SSPCLKIN and produces s_en.
- Everything else lives in ssp_rx_logic.

## Test plan
- Single frame, FIFO empty: PCLK = 2×SSPCLKIN, FSS pulse, bits 0xA5 -> rx_ready high for exactly 1 cycle, one PCLK after the LSB sample edge, RxData = 0xA5, RXOVR = 0.
- Back-to-back frames: 0x3C then 0xC3, with FSS high during the LSB of the first -> two strobes 8 SSPCLKIN periods apart, RxData 0x3C then 0xC3.
- Full back-pressure: SSPRXINTR = 1 through frame 0x5A, then low 10 cycles later -> no strobe while full; strobe with RxData = 0x5A one cycle after release.
- Overrun: SSPRXINTR held 1 across frames 0x11 and 0x22, then low -> RXOVR = 1 after the 0x22 LSB; a single strobe with RxData = 0x11.
- Mid-frame FSS: FSS asserted after 4 bits, then full frame 0x81 -> no strobe for the partial word; one strobe with RxData = 0x81; RXOVR = 0.
- Reset mid-frame: CLEAR for 1 cycle after 5 bits, then frame 0xFF -> all outputs 0 the cycle after CLEAR; next strobe RxData = 0xFF; no spurious strobe.
